// File: rtl/clock_adjust_ctrl.sv
// Front-panel adjust sequencer: debounces MODE/UP/DOWN, walks the field-select
// FSM, and emits adjust pulses with auto-repeat, inactivity timeout and blink.
module clock_adjust_ctrl #(
    parameter int unsigned DEBOUNCE_MS     = 20,
    parameter int unsigned REPEAT_DELAY_MS = 500,
    parameter int unsigned REPEAT_RATE_MS  = 100,
    parameter int unsigned TIMEOUT_MS      = 10000,
    parameter int unsigned BLINK_MS        = 250,
    parameter int unsigned CNT_W           = 14
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_ms,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [5:0] adj_en,
    output logic       adj_up,
    output logic       adj_down,
    output logic [2:0] field,
    output logic       blink
);

    typedef enum logic [2:0] {
        ST_RUN  = 3'd0,
        ST_SEC  = 3'd1,
        ST_MIN  = 3'd2,
        ST_HOUR = 3'd3,
        ST_DAY  = 3'd4,
        ST_MON  = 3'd5,
        ST_YEAR = 3'd6
    } state_e;

    localparam logic [CNT_W-1:0] DEB_C   = CNT_W'(DEBOUNCE_MS);
    localparam logic [CNT_W-1:0] DELAY_C = CNT_W'(REPEAT_DELAY_MS);
    localparam logic [CNT_W-1:0] RATE_C  = CNT_W'(REPEAT_RATE_MS);
    localparam logic [CNT_W-1:0] TO_C    = CNT_W'(TIMEOUT_MS);
    localparam logic [CNT_W-1:0] BLINK_C = CNT_W'(BLINK_MS);

    // Button vectors are ordered [0]=MODE [1]=UP [2]=DOWN
    logic [2:0]       raw;
    logic [2:0]       sync1_q, sync2_q, deb_q, deb_prev_q;
    logic [CNT_W-1:0] dcnt_q [3];
    logic [2:0]       rise;

    assign raw  = {btn_down, btn_up, btn_mode};
    assign rise = deb_q & ~deb_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            for (int unsigned i = 0; i < 3; i++) dcnt_q[i] <= '0;
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            deb_prev_q <= deb_q;
            if (tick_ms) begin
                for (int unsigned i = 0; i < 3; i++) begin
                    if (sync2_q[i] != deb_q[i]) begin
                        if (dcnt_q[i] + 1'b1 == DEB_C) begin
                            deb_q[i]  <= sync2_q[i];
                            dcnt_q[i] <= '0;
                        end else begin
                            dcnt_q[i] <= dcnt_q[i] + 1'b1;
                        end
                    end else begin
                        dcnt_q[i] <= '0;
                    end
                end
            end
        end
    end

    state_e           state_q, state_d;
    logic [5:0]       adj_en_q, adj_en_d;
    logic             adj_up_q, adj_up_d, adj_down_q, adj_down_d;
    logic             blink_q, blink_d;
    logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
    logic [CNT_W-1:0] inact_q, inact_d;
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_phase_q, rep_phase_d;
    logic             rep_en_q, rep_en_d;

    logic             mode_ev, up_ok, dn_ok, any_ev, hold_one, rep_hit, rep_fire;
    logic [CNT_W-1:0] rep_tgt;

    function automatic state_e next_field(input state_e s);
        case (s)
            ST_RUN:  next_field = ST_SEC;
            ST_SEC:  next_field = ST_MIN;
            ST_MIN:  next_field = ST_HOUR;
            ST_HOUR: next_field = ST_DAY;
            ST_DAY:  next_field = ST_MON;
            ST_MON:  next_field = ST_YEAR;
            default: next_field = ST_RUN;
        endcase
    endfunction

    function automatic logic [5:0] field_onehot(input state_e s);
        case (s)
            ST_SEC:  field_onehot = 6'b000001;
            ST_MIN:  field_onehot = 6'b000010;
            ST_HOUR: field_onehot = 6'b000100;
            ST_DAY:  field_onehot = 6'b001000;
            ST_MON:  field_onehot = 6'b010000;
            ST_YEAR: field_onehot = 6'b100000;
            default: field_onehot = 6'b000000;
        endcase
    endfunction

    always_comb begin
        mode_ev  = rise[0];
        any_ev   = |rise;
        up_ok    = rise[1] && !deb_q[2];
        dn_ok    = rise[2] && !deb_q[1];
        hold_one = deb_q[1] ^ deb_q[2];
        rep_tgt  = rep_phase_q ? RATE_C : DELAY_C;
        rep_hit  = tick_ms && (rep_cnt_q + 1'b1 == rep_tgt);
        rep_fire = rep_en_q && hold_one && rep_hit;

        state_d     = state_q;
        adj_up_d    = 1'b0;
        adj_down_d  = 1'b0;
        blink_d     = blink_q;
        blink_cnt_d = blink_cnt_q;
        inact_d     = inact_q;
        rep_cnt_d   = rep_cnt_q;
        rep_phase_d = rep_phase_q;
        rep_en_d    = rep_en_q;

        if (state_q == ST_RUN || mode_ev) begin
            // MODE wins over a coincident UP/DOWN event; every entry restarts blink and timeout
            if (mode_ev) state_d = next_field(state_q);
            blink_d     = mode_ev && (state_d != ST_RUN);
            blink_cnt_d = '0;
            inact_d     = '0;
            rep_cnt_d   = '0;
            rep_phase_d = 1'b0;
            rep_en_d    = 1'b0;
        end else if (inact_q == TO_C && !any_ev && !rep_fire) begin
            state_d     = ST_RUN;
            blink_d     = 1'b0;
            blink_cnt_d = '0;
            inact_d     = '0;
            rep_cnt_d   = '0;
            rep_phase_d = 1'b0;
            rep_en_d    = 1'b0;
        end else begin
            if (any_ev || rep_fire) inact_d = '0;
            else if (tick_ms && inact_q != TO_C) inact_d = inact_q + 1'b1;

            if (tick_ms) begin
                if (blink_cnt_q + 1'b1 == BLINK_C) begin
                    blink_d     = ~blink_q;
                    blink_cnt_d = '0;
                end else begin
                    blink_cnt_d = blink_cnt_q + 1'b1;
                end
            end

            if (up_ok || dn_ok) begin
                adj_up_d    = up_ok;
                adj_down_d  = dn_ok;
                rep_en_d    = 1'b1;
                rep_cnt_d   = '0;
                rep_phase_d = 1'b0;
            end else if (rep_en_q && hold_one) begin
                if (rep_hit) begin
                    adj_up_d    = deb_q[1];
                    adj_down_d  = deb_q[2];
                    rep_cnt_d   = '0;
                    rep_phase_d = 1'b1;
                end else if (tick_ms) begin
                    rep_cnt_d = rep_cnt_q + 1'b1;
                end
            end else begin
                // Release or both held: repeat disarms until a fresh accepted press
                rep_en_d    = 1'b0;
                rep_cnt_d   = '0;
                rep_phase_d = 1'b0;
            end
        end

        adj_en_d = field_onehot(state_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            adj_en_q    <= '0;
            adj_up_q    <= 1'b0;
            adj_down_q  <= 1'b0;
            blink_q     <= 1'b0;
            blink_cnt_q <= '0;
            inact_q     <= '0;
            rep_cnt_q   <= '0;
            rep_phase_q <= 1'b0;
            rep_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            adj_en_q    <= adj_en_d;
            adj_up_q    <= adj_up_d;
            adj_down_q  <= adj_down_d;
            blink_q     <= blink_d;
            blink_cnt_q <= blink_cnt_d;
            inact_q     <= inact_d;
            rep_cnt_q   <= rep_cnt_d;
            rep_phase_q <= rep_phase_d;
            rep_en_q    <= rep_en_d;
        end
    end

    assign adj_en   = adj_en_q;
    assign adj_up   = adj_up_q;
    assign adj_down = adj_down_q;
    assign field    = state_q;
    assign blink    = blink_q;

endmodule

// File: tb/tb_clock_adjust_ctrl.sv
// Directed bench for clock_adjust_ctrl: expected adj pulses (direction, ms index)
// are queued as stimulus is driven and matched against pulses seen on the outputs.
module tb_clock_adjust_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick_ms;
    logic       btn_mode, btn_up, btn_down;
    logic [5:0] adj_en;
    logic       adj_up, adj_down;
    logic [2:0] field;
    logic       blink;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned ms_cnt   = 0;
    int unsigned exp_field = 0;
    int unsigned p;

    logic [32:0] exp_q[$];
    logic [32:0] obs_q[$];

    clock_adjust_ctrl #(
        .DEBOUNCE_MS    (2),
        .REPEAT_DELAY_MS(5),
        .REPEAT_RATE_MS (2),
        .TIMEOUT_MS     (20),
        .BLINK_MS       (3),
        .CNT_W          (14)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick_ms (tick_ms),
        .btn_mode(btn_mode),
        .btn_up  (btn_up),
        .btn_down(btn_down),
        .adj_en  (adj_en),
        .adj_up  (adj_up),
        .adj_down(adj_down),
        .field   (field),
        .blink   (blink)
    );

    always #5 clk = ~clk;

    // Every cycle adj_up/adj_down is high becomes one record, so a wide pulse shows as a duplicate
    always @(negedge clk) begin
        if (adj_up === 1'b1)   obs_q.push_back({1'b1, ms_cnt});
        if (adj_down === 1'b1) obs_q.push_back({1'b0, ms_cnt});
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            repeat (3) @(posedge clk);
            #1 tick_ms = 1'b1;
            ms_cnt++;
            @(posedge clk);
            #1 tick_ms = 1'b0;
            repeat (3) @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [5:0] model_onehot(input int unsigned f);
        model_onehot = (f == 0) ? 6'd0 : 6'(1 << (f - 1));
    endfunction

    task automatic sb_check(input string tag);
        logic [32:0] e, o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() > 0) o = obs_q.pop_front();
            else o = '1;
            check(tag, 64'(o), 64'(e));
        end
        check({tag, "_extra"}, 64'(obs_q.size()), 64'd0);
        obs_q.delete();
    endtask

    task automatic mode_press();
        btn_mode = 1'b1;
        tick(2);
        btn_mode = 1'b0;
        tick(2);
        exp_field = (exp_field == 6) ? 0 : exp_field + 1;
        check("field", 64'(field), 64'(exp_field));
        check("adj_en", 64'(adj_en), 64'(model_onehot(exp_field)));
    endtask

    initial begin
        rst_n = 1'b0; tick_ms = 1'b0;
        btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_adj_en", 64'(adj_en), 64'd0);
        check("rst_adj_up", 64'(adj_up), 64'd0);
        check("rst_adj_down", 64'(adj_down), 64'd0);
        check("rst_field", 64'(field), 64'd0);
        check("rst_blink", 64'(blink), 64'd0);
        rst_n = 1'b1;

        // Full MODE walk back to RUN, no adjust pulses
        for (int k = 0; k < 7; k++) mode_press();
        sb_check("walk_pulses");

        // SEC entry: blink starts high, toggles every 3 ticks
        mode_press();
        check("blink_2", 64'(blink), 64'd1);
        tick(1);
        check("blink_3", 64'(blink), 64'd0);
        tick(2);
        check("blink_5", 64'(blink), 64'd0);
        tick(1);
        check("blink_6", 64'(blink), 64'd1);

        // HOUR idle timeout
        mode_press();
        mode_press();
        tick(17);
        check("to_19_field", 64'(field), 64'd3);
        tick(1);
        exp_field = 0;
        check("to_20_field", 64'(field), 64'd0);
        check("to_20_adj_en", 64'(adj_en), 64'd0);
        check("to_20_blink", 64'(blink), 64'd0);

        // HOUR: press at 19 ms restarts the window
        mode_press(); mode_press(); mode_press();
        tick(15);
        btn_up = 1'b1;
        tick(2);
        exp_q.push_back({1'b1, ms_cnt});
        btn_up = 1'b0;
        tick(19);
        check("restart_38_field", 64'(field), 64'd3);
        sb_check("restart_pulse");
        tick(1);
        exp_field = 0;
        check("restart_39_field", 64'(field), 64'd0);
        check("restart_39_adj_en", 64'(adj_en), 64'd0);
        check("restart_39_blink", 64'(blink), 64'd0);

        // DAY: UP+DOWN together, then DOWN release, then UP re-press
        mode_press(); mode_press(); mode_press(); mode_press();
        btn_up = 1'b1; btn_down = 1'b1;
        tick(10);
        btn_down = 1'b0;
        tick(5);
        sb_check("both_held");
        btn_up = 1'b0;
        tick(3);
        btn_up = 1'b1;
        tick(2);
        exp_q.push_back({1'b1, ms_cnt});
        btn_up = 1'b0;
        tick(3);
        sb_check("repress_pulse");
        check("day_field", 64'(field), 64'd4);

        // MON: UP held 12 ms raw -> press pulse then repeats at +5,+7,+9,+11
        mode_press();
        btn_up = 1'b1;
        tick(2);
        p = ms_cnt;
        exp_q.push_back({1'b1, p});
        exp_q.push_back({1'b1, p + 5});
        exp_q.push_back({1'b1, p + 7});
        exp_q.push_back({1'b1, p + 9});
        exp_q.push_back({1'b1, p + 11});
        tick(10);
        btn_up = 1'b0;
        tick(2);
        sb_check("repeat");

        // MODE glitch for one tick is rejected; UP for two ticks is accepted
        btn_mode = 1'b1;
        tick(1);
        btn_mode = 1'b0;
        tick(3);
        check("glitch_field", 64'(field), 64'd5);
        check("glitch_adj_en", 64'(adj_en), 64'b010000);
        btn_up = 1'b1;
        tick(2);
        exp_q.push_back({1'b1, ms_cnt});
        btn_up = 1'b0;
        tick(3);
        sb_check("short_up");

        // SEC: MODE and UP press in the same clk
        mode_press(); mode_press(); mode_press();
        btn_mode = 1'b1; btn_up = 1'b1;
        tick(2);
        check("simul_field", 64'(field), 64'd2);
        check("simul_adj_en", 64'(adj_en), 64'b000010);
        tick(6);
        btn_mode = 1'b0; btn_up = 1'b0;
        tick(3);
        sb_check("simul_no_pulse");

        // Fresh UP press, then async reset on the first repeat pulse
        btn_up = 1'b1;
        tick(2);
        exp_q.push_back({1'b1, ms_cnt});
        tick(4);
        sb_check("pre_reset");
        repeat (3) @(posedge clk);
        #1 tick_ms = 1'b1;
        ms_cnt++;
        @(posedge clk);
        #1 tick_ms = 1'b0;
        check("repeat_before_reset", 64'(adj_up), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_adj_en", 64'(adj_en), 64'd0);
        check("arst_adj_up", 64'(adj_up), 64'd0);
        check("arst_adj_down", 64'(adj_down), 64'd0);
        check("arst_field", 64'(field), 64'd0);
        check("arst_blink", 64'(blink), 64'd0);
        btn_up = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick(2);
        sb_check("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_adjust_ctrl.md
Name: clock_adjust_ctrl

Overview:
Front-panel adjust sequencer for the century clock. Debounces three push-buttons (MODE/UP/DOWN) and walks a field-select FSM RUN -> SEC -> MIN -> HOUR -> DAY -> MON -> YEAR -> RUN. It drives one-hot adj_en to the per-field count/adjust counters, plus single-cycle adj_up/adj_down pulses with auto-repeat. An inactivity timeout and a blink output for the display are included. Sits between the button pins and the count_adjust_* counter chain.

Parameters:
DEBOUNCE_MS, 20, consecutive tick_ms samples a raw level must hold before it is accepted
REPEAT_DELAY_MS, 500, hold time after press before the first auto-repeat pulse
REPEAT_RATE_MS, 100, auto-repeat period after the first repeat
TIMEOUT_MS, 10000, inactivity time in adjust mode before returning to RUN
BLINK_MS, 250, blink half-period
CNT_W, 14, width of the internal ms counters; must hold TIMEOUT_MS

Ports:
clk  in  1  system clock
rst_n  in  1  async active-low reset
tick_ms  in  1  one-clk pulse every 1 ms
btn_mode  in  1  raw MODE button, async, active-high
btn_up  in  1  raw UP button, async, active-high
btn_down  in  1  raw DOWN button, async, active-high
adj_en  out  6  one-hot field enable: [0]sec [1]min [2]hour [3]day [4]mon [5]year; 0 in RUN
adj_up  out  1  one-clk increment pulse, shared by all fields
adj_down  out  1  one-clk decrement pulse, shared by all fields
field  out  3  0=RUN, 1=SEC, 2=MIN, 3=HOUR, 4=DAY, 5=MON, 6=YEAR
blink  out  1  display blink; 0 in RUN

Behaviour:
- Reset: adj_en=0, adj_up=0, adj_down=0, field=0, blink=0; FSM=RUN; debounced levels=0; all counters=0. Reset mid-adjust aborts immediately to RUN.
- Input path: each button uses a 2-FF synchronizer, then a debouncer.
  - The debounced level changes only after the synced level differs from it on DEBOUNCE_MS consecutive tick_ms.
  - A bounce resets the count.
- A press event is the one-clk rising edge of a debounced level.
- FSM:
  - A MODE press advances one state; YEAR -> RUN.
  - Any state -> RUN on timeout.
  - States are encoded as the field values.
- adj_en:
  - Registered; equals the one-hot of the current state and is held continuously while in that state.
  - This suppresses the normal carry path of the selected counter.
  - Updates one clk after the MODE press event.
- Up/down pulses (adjust states only; never in RUN):
  - An UP press event with DOWN debounced-low gives adj_up=1 for exactly one clk, one clk after the event. DOWN is symmetric.
  - Both debounced-high: no pulses, and the repeat counter is held at 0.
  - Auto-repeat: while the button stays held, the first repeat pulse comes REPEAT_DELAY_MS ticks after the press. Further pulses follow every REPEAT_RATE_MS ticks.
  - Releasing the button stops pulses and clears the repeat counter.
- Simultaneous events:
  - A MODE press in the same clk as an UP/DOWN press: MODE wins, no adj pulse is emitted, and the repeat counter clears.
  - Any MODE press clears the repeat counter. A held UP/DOWN does not resume repeating in the new field until released and pressed again.
- Pulse/enable ordering: adj_up/adj_down are never asserted in the same clk that adj_en changes.
- Timeout:
  - The inactivity counter counts tick_ms in adjust states.
  - It clears on entry to any adjust state, on any press event, and on every auto-repeat pulse.
  - At TIMEOUT_MS it goes to RUN next clk with adj_en=0.
  - The counter saturates and never wraps.
- Blink:
  - On entry to an adjust state, blink=1 and the blink counter clears.
  - It toggles every BLINK_MS ticks and is forced to 0 in RUN.
- Counter rules: all ms counters are CNT_W wide and compare with ==; they advance only on tick_ms.

Test Plan:
Use DEBOUNCE_MS=2, REPEAT_DELAY_MS=5, REPEAT_RATE_MS=2, TIMEOUT_MS=20, BLINK_MS=3 for all scenarios.
- Reset then 7 clean MODE presses -> field steps 1..6 then 0; adj_en = 000001, 000010, ..., 100000, 000000; no adj_up/adj_down pulses.
- Field=MON, UP held 12 ms -> one pulse at press, then repeats at 5, 7, 9, 11 ms = 5 adj_up pulses, each exactly 1 clk wide.
- MODE input glitches high for 1 tick then low -> no press event, field unchanged; UP held 2 ticks -> accepted press.
- Field=DAY, UP and DOWN held together 10 ms -> zero pulses; release DOWN -> no pulse until UP is re-pressed.
- Field=HOUR, idle 20 ms -> field=0, adj_en=0, blink=0; a press at 19 ms restarts the 20 ms timeout window.
- Field=SEC, MODE and UP press events in the same clk -> field=MIN, no adj_up; assert rst_n low mid-repeat -> all outputs 0 asynchronously.
